// File: rtl/apu_pkg.sv
// Shared offsets, status bit positions and sequencer mode encoding for the APU MMIO block.
package apu_pkg;

  localparam logic [4:0] ADDR_OAMDMA = 5'h14;
  localparam logic [4:0] ADDR_STATUS = 5'h15;
  localparam logic [4:0] ADDR_JOY    = 5'h16;
  localparam logic [4:0] ADDR_FRAME  = 5'h17;

  localparam int unsigned FRAME_IRQ_BIT = 6;
  localparam int unsigned DMC_IRQ_BIT   = 7;
  localparam int unsigned NUM_REGS      = 32;

  typedef enum logic {
    SEQ_4STEP = 1'b0,
    SEQ_5STEP = 1'b1
  } seq_mode_e;

  // $4014 (OAM DMA) and $4016 (joypad) belong to other units and are not stored here.
  function automatic logic addr_stored(input logic [4:0] addr);
    return (addr != ADDR_OAMDMA) && (addr != ADDR_JOY);
  endfunction

endpackage

// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: cycle/step counters, 4/5-step decode, quarter/half strobes and frame IRQ flag.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned QTR_PERIOD = 7457
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_wr_i,
  input  logic [7:0] frame_data_i,
  input  logic       status_rd_i,
  output logic       qtr_o,
  output logic       half_o,
  output logic       frame_irq_o
);

  localparam int unsigned CW = (QTR_PERIOD > 1) ? $clog2(QTR_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_PERIOD - 1);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    step_q, step_d;
  seq_mode_e     mode_q, mode_d;
  logic          inhibit_q, inhibit_d;
  logic          qtr_q, qtr_d;
  logic          half_q, half_d;
  logic          irq_q, irq_d;
  logic          tick;
  logic          set_irq;

  always_comb begin
    tick      = (cyc_q == LAST) && !frame_wr_i;
    cyc_d     = (cyc_q == LAST) ? '0 : cyc_q + CW'(1);
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    qtr_d     = 1'b0;
    half_d    = 1'b0;
    set_irq   = 1'b0;
    irq_d     = irq_q;

    if (tick) begin
      if (mode_q == SEQ_4STEP) begin
        qtr_d   = 1'b1;
        half_d  = step_q[0];
        set_irq = (step_q == 3'd3) && !inhibit_q;
        step_d  = (step_q == 3'd3) ? 3'd0 : step_q + 3'd1;
      end else begin
        qtr_d   = (step_q != 3'd3);
        half_d  = (step_q == 3'd1) || (step_q == 3'd4);
        step_d  = (step_q == 3'd4) ? 3'd0 : step_q + 3'd1;
      end
    end

    // Ordering gives set priority over read-clear, and inhibit-write priority over both.
    if (status_rd_i) irq_d = 1'b0;
    if (set_irq)     irq_d = 1'b1;

    if (frame_wr_i) begin
      mode_d    = frame_data_i[7] ? SEQ_5STEP : SEQ_4STEP;
      inhibit_d = frame_data_i[6];
      cyc_d     = '0;
      step_d    = '0;
      qtr_d     = frame_data_i[7];
      half_d    = frame_data_i[7];
      if (frame_data_i[6]) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q     <= '0;
      step_q    <= '0;
      mode_q    <= SEQ_4STEP;
      inhibit_q <= 1'b0;
      qtr_q     <= 1'b0;
      half_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      qtr_q     <= qtr_d;
      half_q    <= half_d;
      irq_q     <= irq_d;
    end
  end

  assign qtr_o       = qtr_q;
  assign half_o      = half_q;
  assign frame_irq_o = irq_q;

endmodule

// File: rtl/apu_mmio_frame_regs.sv
// APU MMIO register file ($4000-$401F) with write strobes, $4015 status read-back and frame sequencer.
module apu_mmio_frame_regs
  import apu_pkg::*;
#(
  parameter int unsigned NUM_CH     = 5,
  parameter int unsigned QTR_PERIOD = 7457,
  parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
  input  logic                  i_clk_cpu,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic                  i_rnw,
  input  logic [4:0]            i_addr,
  input  logic [7:0]            i_data_in,
  input  logic [NUM_CH-1:0]     i_ch_active,
  input  logic                  i_dmc_irq,
  output logic [7:0]            o_data_out,
  output logic [32*8-1:0]       o_regs,
  output logic [31:0]           o_wr_stb,
  output logic [NUM_CH-1:0]     o_ch_enable,
  output logic                  o_dmc_irq_clr,
  output logic                  o_qtr_frame,
  output logic                  o_half_frame,
  output logic                  o_irq
);

  logic [7:0]        regs_q [NUM_REGS];
  logic [31:0]       wr_stb_q, wr_stb_d;
  logic [NUM_CH-1:0] ch_enable_q, ch_enable_d;
  logic              dmc_clr_q, dmc_clr_d;
  logic              wr_en;
  logic              status_rd;
  logic              frame_wr;
  logic              frame_irq;
  logic [7:0]        status;

  always_comb begin
    wr_en       = i_ce && !i_rnw && addr_stored(i_addr);
    status_rd   = i_ce && i_rnw && (i_addr == ADDR_STATUS);
    frame_wr    = i_ce && !i_rnw && (i_addr == ADDR_FRAME);
    wr_stb_d    = wr_en ? (32'd1 << i_addr) : '0;
    dmc_clr_d   = i_ce && !i_rnw && (i_addr == ADDR_STATUS);
    ch_enable_d = dmc_clr_d ? i_data_in[NUM_CH-1:0] : ch_enable_q;
  end

  always_ff @(posedge i_clk_cpu or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
      wr_stb_q    <= '0;
      ch_enable_q <= '0;
      dmc_clr_q   <= 1'b0;
    end else begin
      if (wr_en) regs_q[i_addr] <= i_data_in;
      wr_stb_q    <= wr_stb_d;
      ch_enable_q <= ch_enable_d;
      dmc_clr_q   <= dmc_clr_d;
    end
  end

  apu_frame_sequencer #(
    .QTR_PERIOD (QTR_PERIOD)
  ) u_seq (
    .clk_i        (i_clk_cpu),
    .rst_ni       (i_reset),
    .frame_wr_i   (frame_wr),
    .frame_data_i (i_data_in),
    .status_rd_i  (status_rd),
    .qtr_o        (o_qtr_frame),
    .half_o       (o_half_frame),
    .frame_irq_o  (frame_irq)
  );

  always_comb begin
    status                     = '0;
    status[NUM_CH-1:0]         = i_ch_active;
    status[FRAME_IRQ_BIT]      = frame_irq;
    status[DMC_IRQ_BIT]        = i_dmc_irq;
  end

  // Read path is combinational but forced to open bus while reset is held.
  assign o_data_out = (i_reset && status_rd) ? status : OPEN_BUS;

  always_comb begin
    o_regs = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++) o_regs[8*n +: 8] = regs_q[n];
  end

  assign o_wr_stb      = wr_stb_q;
  assign o_ch_enable   = ch_enable_q;
  assign o_dmc_irq_clr = dmc_clr_q;
  assign o_irq         = frame_irq | i_dmc_irq;

endmodule

// File: tb/tb_apu_mmio_frame_regs.sv
// Bench for apu_mmio_frame_regs: directed scenarios plus random bus traffic against an edge-count model.
module tb_apu_mmio_frame_regs;

  localparam int unsigned P  = 4;
  localparam int unsigned NC = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce = 1'b0;
  logic          rnw = 1'b1;
  logic [4:0]    addr = '0;
  logic [7:0]    din = '0;
  logic [NC-1:0] act = '0;
  logic          dmc = 1'b0;
  logic [7:0]    dout;
  logic [255:0]  regs;
  logic [31:0]   stb;
  logic [NC-1:0] ch_en;
  logic          dclr, qtr, half, irq;

  int checks = 0;
  int errors = 0;

  apu_mmio_frame_regs #(
    .NUM_CH     (NC),
    .QTR_PERIOD (P),
    .OPEN_BUS   (8'hFF)
  ) dut (
    .i_clk_cpu     (clk),
    .i_reset       (rst_n),
    .i_ce          (ce),
    .i_rnw         (rnw),
    .i_addr        (addr),
    .i_data_in     (din),
    .i_ch_active   (act),
    .i_dmc_irq     (dmc),
    .o_data_out    (dout),
    .o_regs        (regs),
    .o_wr_stb      (stb),
    .o_ch_enable   (ch_en),
    .o_dmc_irq_clr (dclr),
    .o_qtr_frame   (qtr),
    .o_half_frame  (half),
    .o_irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] actual, input logic [255:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, actual, required, $time);
    end
  endtask

  // Model: t = edges since the last restart; a step boundary occurs whenever t is a multiple of P.
  logic [7:0]    m_regs [32];
  logic [31:0]   m_stb = '0;
  logic [NC-1:0] m_en = '0;
  logic          m_clr = 1'b0, m_q = 1'b0, m_h = 1'b0, m_firq = 1'b0, m_5step = 1'b0, m_inh = 1'b0;
  int unsigned   m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 32; n++) m_regs[n] = 8'h00;
      m_stb = '0; m_en = '0; m_clr = 0; m_q = 0; m_h = 0;
      m_firq = 0; m_5step = 0; m_inh = 0; m_t = 0;
    end else begin
      m_stb = '0; m_clr = 0; m_q = 0; m_h = 0;
      if (ce && !rnw && addr != 5'h14 && addr != 5'h16) begin
        m_regs[addr] = din;
        m_stb[addr] = 1'b1;
      end
      if (ce && !rnw && addr == 5'h15) begin
        m_en = din[NC-1:0];
        m_clr = 1;
      end
      if (ce && !rnw && addr == 5'h17) begin
        m_5step = din[7];
        m_inh = din[6];
        m_t = 0;
        m_q = din[7];
        m_h = din[7];
        if (din[6]) m_firq = 0;
      end else begin
        if (ce && rnw && addr == 5'h15) m_firq = 0;
        m_t = m_t + 1;
        if (m_t % P == 0) begin
          int unsigned k;
          if (!m_5step) begin
            k = (m_t / P - 1) % 4;
            m_q = 1;
            m_h = (k == 1 || k == 3);
            if (k == 3 && !m_inh) m_firq = 1;
          end else begin
            k = (m_t / P - 1) % 5;
            m_q = (k != 3);
            m_h = (k == 1 || k == 4);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [255:0] ef;
    logic [7:0]   ed;
    for (int n = 0; n < 32; n++) ef[8*n +: 8] = m_regs[n];
    if (rst_n && ce && rnw && addr == 5'h15)
      ed = 8'((int'(dmc) << 7) + (int'(m_firq) << 6) + int'(act));
    else
      ed = 8'hFF;
    chk("regs", regs, ef);
    chk("wr_stb", 256'(stb), 256'(m_stb));
    chk("ch_enable", 256'(ch_en), 256'(m_en));
    chk("dmc_irq_clr", 256'(dclr), 256'(m_clr));
    chk("qtr_frame", 256'(qtr), 256'(m_q));
    chk("half_frame", 256'(half), 256'(m_h));
    chk("irq", 256'(irq), 256'(m_firq | dmc));
    chk("data_out", 256'(dout), 256'(ed));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    ce = 1; rnw = 0; addr = a; din = d;
    cyc(1);
    ce = 0; rnw = 1;
  endtask

  initial begin
    int qc, hc;
    rst_n = 1'b0;
    #1;
    chk("rst_data_out", 256'(dout), 256'(8'hFF));
    chk("rst_regs", regs, 256'd0);
    cyc(2);
    rst_n = 1'b1;

    wr(5'h03, 8'h5A);
    chk("reg3_value", 256'(regs[8*3 +: 8]), 256'(8'h5A));
    chk("reg3_strobe", 256'(stb), 256'(32'h0000_0008));
    cyc(1);
    chk("reg3_strobe_drop", 256'(stb), 256'd0);
    wr(5'h14, 8'hC3);
    chk("oamdma_no_strobe", 256'(stb), 256'd0);
    chk("oamdma_no_store", 256'(regs[8*20 +: 8]), 256'd0);

    act = 5'b10101; dmc = 1; ce = 1; rnw = 1; addr = 5'h15;
    #1 chk("status_read", 256'(dout), 256'(8'h95));
    addr = 5'h03;
    #1 chk("other_read", 256'(dout), 256'(8'hFF));
    addr = 5'h15; ce = 0;
    #1 chk("ce_low_read", 256'(dout), 256'(8'hFF));
    dmc = 0;
    cyc(1);

    wr(5'h17, 8'h00);
    qc = 0; hc = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      qc += int'(qtr); hc += int'(half);
    end
    chk("q4_qtr_count", 256'(qc), 256'd4);
    chk("q4_half_count", 256'(hc), 256'd2);
    chk("q4_irq_set", 256'(irq), 256'd1);
    ce = 1; rnw = 1; addr = 5'h15;
    #1 chk("read_irq_bit_set", 256'(dout[6]), 256'd1);
    cyc(1);
    chk("read_irq_bit_cleared", 256'(dout[6]), 256'd0);
    ce = 0;

    wr(5'h17, 8'h80);
    chk("q5_immediate_qtr", 256'(qtr), 256'd1);
    chk("q5_immediate_half", 256'(half), 256'd1);
    qc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      qc += int'(qtr);
    end
    chk("q5_qtr_count", 256'(qc), 256'd4);
    chk("q5_irq_low", 256'(irq), 256'd0);

    wr(5'h17, 8'h00);
    cyc(15);
    ce = 1; rnw = 1; addr = 5'h15;
    #1 chk("read_pre_set", 256'(dout[6]), 256'd0);
    cyc(1);
    chk("set_beats_read_clear", 256'(irq), 256'd1);
    cyc(1);
    ce = 0;
    chk("read_clears_irq", 256'(irq), 256'd0);
    cyc(14);
    wr(5'h17, 8'h40);
    chk("inhibit_beats_set", 256'(irq), 256'd0);
    chk("wrap_write_no_pulse", 256'(qtr), 256'd0);

    wr(5'h15, 8'h1F);
    wr(5'h17, 8'h00);
    cyc(9);
    rst_n = 1'b0;
    #1;
    chk("async_rst_regs", regs, 256'd0);
    chk("async_rst_stb", 256'(stb), 256'd0);
    chk("async_rst_ch_en", 256'(ch_en), 256'd0);
    chk("async_rst_qtr_half", 256'({qtr, half, dclr}), 256'd0);
    chk("async_rst_irq", 256'(irq), 256'd0);
    chk("async_rst_dout", 256'(dout), 256'(8'hFF));
    cyc(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk("first_qtr_after_release", 256'(qtr), 256'(i == 4));
    end

    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      ce  = ($urandom_range(0, 3) != 0);
      rnw = $urandom_range(0, 1) != 0;
      r   = $urandom_range(0, 9);
      if (r < 3)       addr = 5'h15;
      else if (r == 3) addr = 5'h17;
      else if (r == 4) addr = ($urandom_range(0, 1) != 0) ? 5'h14 : 5'h16;
      else             addr = 5'($urandom_range(0, 31));
      if (addr == 5'h17 && !rnw && $urandom_range(0, 3) != 0) ce = 0;
      din = 8'($urandom);
      act = NC'($urandom);
      if ($urandom_range(0, 15) == 0) dmc = ~dmc;
      cyc(1);
    end
    ce = 0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_mmio_frame_regs.md
# apu_mmio_frame_regs

Second-generation APU MMIO block at CPU offsets $4000–$401F: a parametrised register file for NUM_CH sound channels with per-register write strobes, a live $4015 status read-back, and an integrated frame sequencer. The sequencer supports 4-step and 5-step modes and drives quarter-frame and half-frame strobes plus the frame IRQ. Sits between the CPU bus decode and the APU channel units; its outputs feed channel timers and envelopes and the CPU IRQ line.

## Interface
- NUM_CH, 5, number of channels with enable/active bits (1–6)
- QTR_PERIOD, 7457, CPU cycles per sequencer step
- OPEN_BUS, 8'hFF, value driven on o_data_out when not reading $4015
- i_clk_cpu  in  1  CPU clock; one clock only
- i_reset  in  1  reset, asynchronous, active-low
- i_ce  in  1  chip enable, $4000–$401F selected
- i_rnw  in  1  1 = read, 0 = write
- i_addr  in  5  offset within block
- i_data_in  in  8  CPU write data
- i_ch_active  in  NUM_CH  channel length/bytes-remaining nonzero
- i_dmc_irq  in  1  DMC IRQ flag from DMC unit
- o_data_out  out  8  read data
- o_regs  out  32×8 flat  register file contents, reg n at [8n+7:8n]
- o_wr_stb  out  32  one-cycle pulse, bit n = register n was written
- o_ch_enable  out  NUM_CH  $4015 write bits [NUM_CH-1:0]
- o_dmc_irq_clr  out  1  one-cycle pulse on any $4015 write
- o_qtr_frame  out  1  quarter-frame strobe
- o_half_frame  out  1  half-frame strobe
- o_irq  out  1  frame_irq | i_dmc_irq

## Operation
- Reset: all registers, o_wr_stb, o_ch_enable, mode, inhibit, frame_irq, strobes, and sequencer counters are 0. o_data_out = OPEN_BUS.
- Write (i_ce & ~i_rnw): every offset except $14 and $16 stores to regs[i_addr] and pulses o_wr_stb[i_addr]. $14 and $16 are ignored, with no strobe.
- $4015 write: o_ch_enable <= i_data_in[NUM_CH-1:0]; pulse o_dmc_irq_clr.
- $4017 write: mode <= bit7 (1 = 5-step); inhibit <= bit6; inhibit = 1 clears frame_irq; step and cycle counters reset to 0. If bit7 = 1, o_qtr_frame and o_half_frame pulse on the next cycle.
- Read (i_ce & i_rnw & i_addr==$15): o_data_out = {i_dmc_irq, frame_irq, 0…, i_ch_active}, zero-padded; combinational. All other reads return OPEN_BUS.
- A $4015 read clears frame_irq at the end of the read cycle; the read data shows the pre-clear value.
- Sequencer: cycle counter runs 0..QTR_PERIOD-1; at wrap, step advances.
  - 4-step mode, steps 0..3: quarter pulse on every step; half pulse on steps 1 and 3; step 3 sets frame_irq unless inhibit; step 3 then returns to 0.
  - 5-step mode, steps 0..4: quarter pulse on steps 0, 1, 2, 4; half pulse on steps 1 and 4; step 3 emits nothing; never sets frame_irq.
- Simultaneous events:
  - frame_irq set and $4015 read in the same cycle: set wins.
  - frame_irq set and $4017 write with inhibit: clear wins.
  - $4017 write on the wrap cycle: reset wins; no step pulse.

## Timing
- Register, strobe, enable, and mode updates are visible 1 cycle after the write edge.
- o_wr_stb and o_dmc_irq_clr are high for exactly 1 cycle.
- Strobes are registered and fire in the cycle after the counter reaches QTR_PERIOD-1.
- o_irq rises 1 cycle after the step-3 wrap.
- Read data has 0-cycle latency.
- Asynchronous reset mid-sequence returns every output to its reset value immediately. Counting restarts from 0 on the first edge after release.

## Structure
- Package apu_pkg holds:
  - Offsets: ADDR_STATUS=5'h15, ADDR_FRAME=5'h17, ADDR_OAMDMA=5'h14, ADDR_JOY=5'h16
  - Status bit positions: FRAME_IRQ_BIT=6, DMC_IRQ_BIT=7
  - Mode enum: SEQ_4STEP, SEQ_5STEP
- Sub-module apu_frame_sequencer contains the counters, step decode, and frame_irq logic. The top level holds the register file, strobes, and read mux.

## Test plan
- Reset, then write $4003=8'h5A → regs[3]=8'h5A and a single-cycle o_wr_stb[3] one cycle later; write $4014 → no store, no strobe.
- QTR_PERIOD=4, 4-step, inhibit=0 → quarter pulses every 4 cycles; half pulses on steps 1 and 3; o_irq high after the 16th cycle; reading $4015 returns bit6=1, then bit6=0.
- Write $4017=8'h80 with QTR_PERIOD=4 → quarter and half pulses on the next cycle; over 20 cycles, no quarter pulse at step 3 and o_irq stays 0.
- i_ch_active=5'b10101, i_dmc_irq=1, read $4015 → 8'h95; any other offset, or i_ce=0 → 8'hFF.
- $4015 read on the cycle frame_irq sets → flag remains 1. $4017=8'h40 write on the same cycle → flag 0.
- Assert i_reset mid-step 2 → all outputs at reset values without waiting for a clock edge; after release, first quarter pulse at cycle QTR_PERIOD.
